// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared types for the branch resolution unit:
//   branch_sel_t  - conditional branch selector encoding (BEQ..BGEU, 0..5)
//   bimodal_t     - 2-bit saturating predictor counter plus its named states
//   fsm_state_t   - resolve state machine (RUN / FLUSH)
//   bimodal_update - saturating counter step towards the resolved direction
// -----------------------------------------------------------------------------
package branch_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'd0,
        BNE  = 3'd1,
        BLT  = 3'd2,
        BGE  = 3'd3,
        BLTU = 3'd4,
        BGEU = 3'd5
    } branch_sel_t;

    typedef logic [1:0] bimodal_t;

    localparam bimodal_t SNT       = 2'b00;
    localparam bimodal_t WNT       = 2'b01;
    localparam bimodal_t WT        = 2'b10;
    localparam bimodal_t ST        = 2'b11;
    localparam bimodal_t BHT_RESET = WNT;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fsm_state_t;

    // Move one step towards the observed direction, sticking at the ends.
    function automatic bimodal_t bimodal_update(input bimodal_t cnt, input logic taken);
        bimodal_t res;
        if (taken) begin
            res = (cnt == ST) ? ST : bimodal_t'(cnt + 2'd1);
        end else begin
            res = (cnt == SNT) ? SNT : bimodal_t'(cnt - 2'd1);
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_compare.sv
// -----------------------------------------------------------------------------
// branch_compare
// Combinational branch condition evaluation.
// Ports:
//   sel     in  3     branch selector (branch_sel_t encoding; 6-7 illegal)
//   rs1     in  XLEN  first operand
//   rs2     in  XLEN  second operand
//   taken   out 1     branch condition result (0 for illegal selectors)
//   illegal out 1     selector is outside BEQ..BGEU
// -----------------------------------------------------------------------------
module branch_compare
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      sel,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken,
    output logic            illegal
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1 == rs2);
    assign lt_s = ($signed(rs1) < $signed(rs2));
    assign lt_u = (rs1 < rs2);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (sel)
            BEQ:     taken = eq;
            BNE:     taken = !eq;
            BLT:     taken = lt_s;
            BGE:     taken = !lt_s;
            BLTU:    taken = lt_u;
            BGEU:    taken = !lt_u;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Bimodal branch predictor lookup at fetch plus branch resolution at execute.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   fetch_pc / pred_taken fetch-time lookup, prediction is combinational
//   ex_*                  execute-stage branch being resolved
//   mispredict            registered one-cycle pulse on a wrong prediction
//   redirect_pc           registered correct-path PC, valid with mispredict
//   illegal_sel           registered one-cycle pulse on selector 6/7
//   branch_count          saturating count of resolved branches (incl. illegal)
//   mispredict_count      saturating count of mispredictions
// -----------------------------------------------------------------------------
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic [2:0]       ex_branch_sel,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             illegal_sel,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    bimodal_t         bht_q [BHT_ENTRIES];
    bimodal_t         bht_d [BHT_ENTRIES];
    fsm_state_t       state_q, state_d;
    logic             mispredict_q, mispredict_d;
    logic             illegal_sel_q, illegal_sel_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             cmp_taken;
    logic             cmp_illegal;
    logic             resolve;

    // Only word-index bits of the fetch PC address the table.
    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0]};

    assign fetch_idx  = fetch_pc[IDX_W+1:2];
    assign ex_idx     = ex_pc[IDX_W+1:2];

    // Reads the registered table, so a same-cycle update is not bypassed.
    assign pred_taken = bht_q[fetch_idx][1];

    branch_compare #(
        .XLEN(XLEN)
    ) u_compare (
        .sel     (ex_branch_sel),
        .rs1     (ex_rs1),
        .rs2     (ex_rs2),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Instructions seen during FLUSH are wrong-path and are ignored.
    assign resolve = ex_valid & ex_branch & (state_q == RUN);

    always_comb begin
        bht_d              = bht_q;
        state_d            = RUN;     // FLUSH lasts exactly one cycle
        mispredict_d       = 1'b0;
        illegal_sel_d      = 1'b0;
        redirect_pc_d      = redirect_pc_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;

        if (resolve) begin
            branch_count_d = sat_inc(branch_count_q);
            if (cmp_illegal) begin
                illegal_sel_d = 1'b1;
            end else begin
                bht_d[ex_idx] = bimodal_update(bht_q[ex_idx], cmp_taken);
                if (cmp_taken != ex_pred_taken) begin
                    mispredict_d       = 1'b1;
                    mispredict_count_d = sat_inc(mispredict_count_q);
                    redirect_pc_d      = cmp_taken ? ex_target : ex_pc + XLEN'(4);
                    state_d            = FLUSH;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= BHT_RESET;
            end
            state_q            <= RUN;
            mispredict_q       <= 1'b0;
            illegal_sel_q      <= 1'b0;
            redirect_pc_q      <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            bht_q              <= bht_d;
            state_q            <= state_d;
            mispredict_q       <= mispredict_d;
            illegal_sel_q      <= illegal_sel_d;
            redirect_pc_q      <= redirect_pc_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign mispredict       = mispredict_q;
    assign illegal_sel      = illegal_sel_q;
    assign redirect_pc      = redirect_pc_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Scoreboard bench: each driven execute cycle pushes its expected outputs,
// which are popped and compared one cycle later. CNT_W = 4 so counter
// saturation is reachable.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    localparam int XLEN  = 32;
    localparam int NENT  = 64;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [XLEN-1:0]  fetch_pc;
    logic             pred_taken;
    logic             ex_valid;
    logic             ex_branch;
    logic [2:0]       ex_branch_sel;
    logic [XLEN-1:0]  ex_rs1, ex_rs2, ex_pc, ex_target;
    logic             ex_pred_taken;
    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;
    logic             illegal_sel;
    logic [CNT_W-1:0] branch_count, mispredict_count;

    branch_resolve_unit #(
        .XLEN(XLEN), .BHT_ENTRIES(NENT), .CNT_W(CNT_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_pc         (fetch_pc),
        .pred_taken       (pred_taken),
        .ex_valid         (ex_valid),
        .ex_branch        (ex_branch),
        .ex_branch_sel    (ex_branch_sel),
        .ex_rs1           (ex_rs1),
        .ex_rs2           (ex_rs2),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .illegal_sel      (illegal_sel),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             mp;
        logic             ill;
        logic [XLEN-1:0]  rd;
        logic [CNT_W-1:0] bc;
        logic [CNT_W-1:0] mc;
    } exp_t;

    exp_t sb[$];

    // Reference state
    logic [1:0]       bht_m [NENT];
    logic             flush_m;
    logic [CNT_W-1:0] bc_m, mc_m;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic ref_taken(input logic [2:0] s, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        case (s)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return $signed(a) < $signed(b);
            3'd3:    return $signed(a) >= $signed(b);
            3'd4:    return a < b;
            3'd5:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic int idx_of(input logic [XLEN-1:0] pc);
        return int'(pc[7:2]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) bht_m[i] = 2'b01;
        flush_m = 1'b0;
        bc_m    = '0;
        mc_m    = '0;
        sb.delete();
    endtask

    // Drive one execute cycle; fetch_pc looks up the same PC in the same cycle.
    task automatic drive(input string name, input logic v, input logic br, input logic [2:0] sel,
                         input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                         input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt, input logic pt);
        exp_t e;
        exp_t o;
        logic t;
        int   k;
        ex_valid = v; ex_branch = br; ex_branch_sel = sel;
        ex_rs1 = rs1; ex_rs2 = rs2; ex_pc = pc; ex_target = tgt; ex_pred_taken = pt;
        fetch_pc = pc;
        #1;
        k = idx_of(pc);
        chk({name, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, bht_m[k][1]});

        t = ref_taken(sel, rs1, rs2);
        e.mp = 1'b0; e.ill = 1'b0; e.rd = '0;
        if (v && br && !flush_m) begin
            bc_m = sat(bc_m);
            if (sel > 3'd5) begin
                e.ill = 1'b1;
                flush_m = 1'b0;
            end else begin
                if (t && bht_m[k] != 2'b11) bht_m[k] = bht_m[k] + 2'd1;
                else if (!t && bht_m[k] != 2'b00) bht_m[k] = bht_m[k] - 2'd1;
                if (t != pt) begin
                    mc_m = sat(mc_m);
                    e.mp = 1'b1;
                    e.rd = t ? tgt : pc + 32'd4;
                end
                flush_m = e.mp;
            end
        end else begin
            flush_m = 1'b0;
        end
        e.bc = bc_m; e.mc = mc_m;
        sb.push_back(e);

        @(posedge clk);
        #1;
        o = sb.pop_front();
        chk({name, ".mispredict"}, {31'd0, mispredict}, {31'd0, o.mp});
        chk({name, ".illegal_sel"}, {31'd0, illegal_sel}, {31'd0, o.ill});
        if (o.mp) chk({name, ".redirect_pc"}, redirect_pc, o.rd);
        chk({name, ".branch_count"}, {28'd0, branch_count}, {28'd0, o.bc});
        chk({name, ".mispredict_count"}, {28'd0, mispredict_count}, {28'd0, o.mc});
        $display("txn %-12s v=%0b sel=%0d pc=%h pt=%0b -> mp=%0b ill=%0b rd=%h bc=%0d mc=%0d",
                 name, v, sel, pc, pt, mispredict, illegal_sel, redirect_pc, branch_count, mispredict_count);
    endtask

    task automatic idle(input string name, input logic [XLEN-1:0] pc);
        drive(name, 1'b0, 1'b0, 3'd0, '0, '0, pc, '0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        model_reset();
        chk("rst.mispredict", {31'd0, mispredict}, 32'd0);
        chk("rst.illegal_sel", {31'd0, illegal_sel}, 32'd0);
        chk("rst.redirect_pc", redirect_pc, 32'd0);
        chk("rst.branch_count", {28'd0, branch_count}, 32'd0);
        chk("rst.mispredict_count", {28'd0, mispredict_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [XLEN-1:0] rpc;
        logic [2:0]      rsel;
        logic [XLEN-1:0] ra, rb;
        ex_valid = 0; ex_branch = 0; ex_branch_sel = 0; ex_rs1 = 0; ex_rs2 = 0;
        ex_pc = 0; ex_target = 0; ex_pred_taken = 0; fetch_pc = 0;
        model_reset();

        // Reset defaults, prediction for several PCs
        do_reset();
        idle("rst_pc0", 32'h0000_0000);
        idle("rst_pc1", 32'h0000_0FFC);
        idle("rst_pc2", 32'h1234_5678);

        // Signed vs unsigned compare
        drive("blt_signed", 1, 1, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h300, 1'b0);
        idle("blt_flush", 32'h200);
        drive("bltu_unsgn", 1, 1, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h204, 32'h300, 1'b0);

        // Training and saturation at 0x400: 01 -> 10 -> 11 -> 11
        drive("train1", 1, 1, 3'd0, 32'd5, 32'd5, 32'h400, 32'h500, 1'b0);
        idle("train1_fl", 32'h400);
        drive("train2", 1, 1, 3'd0, 32'd5, 32'd5, 32'h400, 32'h500, 1'b1);
        drive("train3", 1, 1, 3'd0, 32'd5, 32'd5, 32'h400, 32'h500, 1'b1);
        drive("train4", 1, 1, 3'd0, 32'd5, 32'd5, 32'h400, 32'h500, 1'b1);
        // One not-taken from 11 leaves 10, so prediction stays taken
        drive("untrain", 1, 1, 3'd0, 32'd1, 32'd2, 32'h400, 32'h500, 1'b1);
        // Branch in FLUSH at 0x400 would push counter to 01 if not squashed
        drive("flush_sq", 1, 1, 3'd0, 32'd1, 32'd2, 32'h400, 32'h500, 1'b1);
        idle("after_sq", 32'h400);

        // Not-taken mispredict at 0x100 and squash of a FLUSH-cycle branch
        drive("nt_mp", 1, 1, 3'd0, 32'd1, 32'd2, 32'h100, 32'h800, 1'b1);
        drive("flush_sq2", 1, 1, 3'd1, 32'd1, 32'd2, 32'h400, 32'h900, 1'b0);
        idle("after_sq2", 32'h400);

        // Illegal selectors
        drive("illegal7", 1, 1, 3'd7, 32'd3, 32'd3, 32'h400, 32'h500, 1'b0);
        drive("illegal6", 1, 1, 3'd6, 32'd3, 32'd4, 32'h400, 32'h500, 1'b1);
        idle("after_ill", 32'h400);

        // Non-branch valid instruction
        drive("not_branch", 1, 0, 3'd0, 32'd1, 32'd1, 32'h400, 32'h500, 1'b0);

        // Random back-to-back mix
        for (int i = 0; i < 24; i++) begin
            rpc  = {24'd0, 4'($urandom_range(0, 15)), 4'd0};
            rsel = 3'($urandom_range(0, 7));
            ra   = $urandom_range(0, 3) == 0 ? 32'h8000_0000 : 32'($urandom_range(0, 3));
            rb   = 32'($urandom_range(0, 3));
            drive("rand", 1, 1, rsel, ra, rb, rpc, 32'hA000 + rpc, 1'($urandom_range(0, 1)));
        end

        // Counter saturation: 20 mispredicts leave mispredict_count at 15
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive("sat_mp", 1, 1, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'h600, 32'h700, 1'b0);
            idle("sat_fl", 32'h600);
        end
        chk("sat.mispredict_count", {28'd0, mispredict_count}, 32'd15);
        chk("sat.branch_count", {28'd0, branch_count}, 32'd15);

        // Reset asserted in the FLUSH cycle clears everything asynchronously
        drive("pre_rst_mp", 1, 1, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'h600, 32'h700, 1'b0);
        fetch_pc = 32'h600;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst.mispredict", {31'd0, mispredict}, 32'd0);
        chk("midrst.redirect_pc", redirect_pc, 32'd0);
        chk("midrst.mispredict_count", {28'd0, mispredict_count}, 32'd0);
        chk("midrst.branch_count", {28'd0, branch_count}, 32'd0);
        chk("midrst.pred_taken", {31'd0, pred_taken}, 32'd0);
        model_reset();
        #2;
        reset = 1'b0;
        // FLUSH was abandoned, so this branch resolves on the next edge
        drive("post_rst_mp", 1, 1, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'h600, 32'h700, 1'b0);
        idle("post_rst_fl", 32'h600);

        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution and prediction unit for the pipelined core. It replaces the single-cycle combinational branch decision with several pieces of behaviour:
- a bimodal branch history table (BHT) of 2-bit saturating counters, read at fetch;
- full-width operand comparison at execute;
- registered misprediction and redirect outputs;
- a one-cycle wrong-path squash state;
- branch and misprediction statistics counters.

It sits between the fetch PC mux and the execute stage.

## Interface
Parameters:
- XLEN, 32, operand/PC width
- BHT_ENTRIES, 64, number of counters; power of two, ≥ 2
- CNT_W, 32, statistics counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- fetch_pc  in  XLEN  PC being fetched
- pred_taken  out  1  combinational: MSB of BHT[fetch_pc index]
- ex_valid  in  1  execute-stage instruction valid
- ex_branch  in  1  instruction is a conditional branch
- ex_branch_sel  in  3  0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU; 6–7 illegal
- ex_rs1, ex_rs2  in  XLEN  comparison operands
- ex_pc  in  XLEN  branch PC
- ex_target  in  XLEN  taken target
- ex_pred_taken  in  1  prediction carried down the pipe
- mispredict  out  1  registered; one-cycle pulse
- redirect_pc  out  XLEN  registered; valid while mispredict = 1
- illegal_sel  out  1  registered; one-cycle pulse
- branch_count, mispredict_count  out  CNT_W  saturating totals

## Operation
- **Index:** idx = pc[log2(BHT_ENTRIES)+1 : 2].
- **Counter encoding:** 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Reset value of every entry is 01.
- **Resolve condition:** a branch resolves when ex_valid & ex_branch & state==RUN.
- **Comparison:**
  - eq = (rs1 == rs2).
  - lt for BLT/BGE is the signed XLEN compare; lt for BLTU/BGEU is the unsigned compare.
  - taken = eq / !eq / lt / !lt / lt / !lt for sel 0–5.
- **Illegal sel (6–7):**
  - taken = 0 and no BHT update;
  - mispredict = 0, illegal_sel pulses 1;
  - the event is counted in branch_count only.
- **On a legal resolve:**
  - BHT[idx(ex_pc)] increments (saturating at 11) when taken, or decrements (saturating at 00) when not taken.
  - branch_count increments.
  - If taken != ex_pred_taken: mispredict_count increments, mispredict pulses, and redirect_pc = taken ? ex_target : ex_pc + 4 (mod 2^XLEN).
- **FSM:**
  - RUN → FLUSH on a mispredict.
  - FLUSH → RUN unconditionally after one cycle.
  - In FLUSH, execute inputs are wrong-path: no BHT update, no counting, no outputs.
- **Statistics counters** saturate at all-ones and never wrap.
- **Non-resolving cycles:** when ex_valid = 0 or ex_branch = 0, nothing changes and the pulses stay 0.
- **Reset:**
  - mispredict, illegal_sel, redirect_pc, branch_count and mispredict_count are 0; state is RUN; every BHT entry is 01.
  - Reset asserted mid-flush abandons the FLUSH state immediately.

## Timing
- pred_taken: zero latency, combinational from fetch_pc.
- mispredict, redirect_pc, illegal_sel: registered on the edge that samples the resolving branch, so visible 1 cycle after ex inputs are presented.
- BHT write happens on the same edge. A fetch lookup of the same idx in that cycle reads the old value; there is no bypass.
- Back-to-back resolves in RUN are accepted every cycle when no mispredict occurs.
- After a mispredict, the next cycle is FLUSH, so the earliest following resolve is 2 cycles after the mispredicting branch.

## Structure
- Package branch_pkg:
  - branch_sel_t enum, with values BEQ through BGEU at 0–5;
  - the bimodal counter type and its constants: SNT, WNT, WT, ST and BHT_RESET = WNT;
  - the fsm_state_t enum {RUN, FLUSH}.
- One sub-module, branch_compare: the combinational eq/lt/taken computation from sel, rs1 and rs2 (XLEN parametrised). This is the generalised replacement of the old decoder.
- The BHT is a flop array in the top module with an async reset to BHT_RESET. No SRAM macro is used.

## Test plan
- **Reset defaults:** assert reset, then release. Required: pred_taken = 0 for any fetch_pc, both counters = 0, mispredict = 0.
- **Signed vs unsigned compare:** sel = BLT with rs1 = 0xFFFFFFFF, rs2 = 1 → taken; sel = BLTU with the same operands → not taken. Each is checked against ex_pred_taken = 0, so the BLT case must pulse mispredict with redirect_pc = ex_target.
- **Counter training and saturation:** present the same ex_pc taken 4 times in a row (pred 1 after the first). Required: counter path 01 → 10 → 11 → 11, and pred_taken at that pc = 1 from the second resolve on.
- **Not-taken mispredict and squash:** BEQ with rs1 ≠ rs2, pred 1, ex_pc = 0x100. Required: redirect_pc = 0x104 on the next cycle. A branch presented in the FLUSH cycle must cause no count change and no BHT change.
- **Illegal selector:** ex_branch_sel = 7. Required: illegal_sel pulse, branch_count +1, mispredict_count unchanged, BHT unchanged.
- **Counter saturation and mid-flush reset:** with CNT_W = 4, 20 mispredicts leave mispredict_count at 15. Asserting reset during FLUSH clears all state asynchronously.
